regfile_mp: RTL and testbench



---
 rtl/regfile_pkg.sv | 9 +
 rtl/regfile_scoreboard.sv | 48 ++++
 rtl/regfile_mp.sv | 113 +++++++++++
 tb/tb_regfile_mp.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;

  typedef enum logic {RF_CLEAR, RF_READY} rf_state_t;

  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for long-latency writebacks, with NRD lookup ports.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = RF_NREGS,
  parameter int NRD      = 2,
  parameter int AW       = $clog2(RF_NREGS),
  parameter int ZERO_REG = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_set,
  input  logic [AW-1:0]     i_set_rd,
  input  logic              i_clr,
  input  logic [AW-1:0]     i_clr_rd,
  input  logic [NRD*AW-1:0] i_rs,
  output logic [NRD-1:0]    o_pend
);

  logic [NREGS-1:0] r_pend;
  logic [NREGS-1:0] w_set_vec;
  logic [NREGS-1:0] w_clr_vec;

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_bit
      localparam bit IS_ZERO = (ZERO_REG != 0) && (gi == 0);
      assign w_set_vec[gi] = i_en && i_set && (i_set_rd == AW'(gi)) && !IS_ZERO;
      assign w_clr_vec[gi] = i_en && i_clr && (i_clr_rd == AW'(gi));
    end
  endgenerate

  // Set is applied after clear so a same-cycle set on the written register wins.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr_vec) | w_set_vec;
    end
  end

  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_lookup
      assign o_pend[gi] = r_pend[i_rs[gi*AW +: AW]];
    end
  endgenerate

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write bypass, post-reset clear sequencer
// and a pending scoreboard for long-latency writebacks.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = RF_XLEN,
  parameter int NREGS    = RF_NREGS,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NRD*AW-1:0]   i_rs,
  output logic [NRD*XLEN-1:0] o_rs_val,
  output logic [NRD-1:0]      o_rs_busy,
  input  logic [AW-1:0]       i_rd,
  input  logic [XLEN-1:0]     i_rd_val,
  input  logic                i_w_en,
  input  logic                i_busy_set,
  input  logic [AW-1:0]       i_busy_rd,
  output logic                o_ready
);

  rf_state_t       r_state;
  rf_state_t       w_state_next;
  logic [AW-1:0]   r_cnt;
  logic [AW-1:0]   w_cnt_next;
  logic            w_ready;
  logic            w_wr_legal;
  logic            w_we;
  logic [AW-1:0]   w_waddr;
  logic [XLEN-1:0] w_wdata;
  logic [NRD-1:0]  w_pend;
  logic [XLEN-1:0] r_regs [NREGS];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= RF_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Counter stops on the last register rather than wrapping.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (r_state == RF_CLEAR) begin
      if (r_cnt == AW'(NREGS - 1)) begin
        w_state_next = RF_READY;
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end
  end

  assign w_ready    = (r_state == RF_READY);
  assign o_ready    = w_ready;
  assign w_wr_legal = i_w_en && !((ZERO_REG != 0) && (i_rd == '0));
  assign w_we       = !w_ready || w_wr_legal;
  assign w_waddr    = w_ready ? i_rd : r_cnt;
  assign w_wdata    = w_ready ? i_rd_val : '0;

  always_ff @(posedge i_clk) begin
    if (w_we) begin
      r_regs[w_waddr] <= w_wdata;
    end
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NRD      (NRD),
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (w_ready),
    .i_set    (i_busy_set),
    .i_set_rd (i_busy_rd),
    .i_clr    (i_w_en),
    .i_clr_rd (i_rd),
    .i_rs     (i_rs),
    .o_pend   (w_pend)
  );

  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_port
      logic [AW-1:0] w_rs;
      logic          w_zero;
      logic          w_byp;
      logic          w_set_hit;
      logic          w_wr_hit;

      assign w_rs      = i_rs[gi*AW +: AW];
      assign w_zero    = (ZERO_REG != 0) && (w_rs == '0);
      assign w_wr_hit  = i_w_en && (i_rd == w_rs);
      assign w_byp     = (BYPASS != 0) && w_wr_hit && !w_zero;
      assign w_set_hit = i_busy_set && (i_busy_rd == w_rs);

      assign o_rs_val[gi*XLEN +: XLEN] = (!w_ready || w_zero) ? '0 :
                                         w_byp ? i_rd_val : r_regs[w_rs];
      // A same-cycle set on the register being written keeps it busy.
      assign o_rs_busy[gi] = w_ready && !w_zero &&
                             ((w_pend[gi] && !w_byp) || (w_set_hit && w_wr_hit));
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard-driven bench for regfile_mp: default instance plus a
// 16-register, 3-port, 64-bit, no-bypass instance.
module tb_regfile_mp;

  logic clk;

  // Instance A: defaults (XLEN 32, NREGS 32, NRD 2, BYPASS 1)
  logic        a_rst;
  logic [9:0]  a_rs;
  logic [63:0] a_rs_val;
  logic [1:0]  a_rs_busy;
  logic [4:0]  a_rd;
  logic [31:0] a_rd_val;
  logic        a_w_en;
  logic        a_busy_set;
  logic [4:0]  a_busy_rd;
  logic        a_ready;

  // Instance B: XLEN 64, NREGS 16, NRD 3, BYPASS 0
  logic         b_rst;
  logic [11:0]  b_rs;
  logic [191:0] b_rs_val;
  logic [2:0]   b_rs_busy;
  logic [3:0]   b_rd;
  logic [63:0]  b_rd_val;
  logic         b_w_en;
  logic         b_busy_set;
  logic [3:0]   b_busy_rd;
  logic         b_ready;

  regfile_mp u_dut_a (
    .i_clk      (clk),
    .i_rst      (a_rst),
    .i_rs       (a_rs),
    .o_rs_val   (a_rs_val),
    .o_rs_busy  (a_rs_busy),
    .i_rd       (a_rd),
    .i_rd_val   (a_rd_val),
    .i_w_en     (a_w_en),
    .i_busy_set (a_busy_set),
    .i_busy_rd  (a_busy_rd),
    .o_ready    (a_ready)
  );

  regfile_mp #(
    .XLEN     (64),
    .NREGS    (16),
    .NRD      (3),
    .ZERO_REG (1),
    .BYPASS   (0)
  ) u_dut_b (
    .i_clk      (clk),
    .i_rst      (b_rst),
    .i_rs       (b_rs),
    .o_rs_val   (b_rs_val),
    .o_rs_busy  (b_rs_busy),
    .i_rd       (b_rd),
    .i_rd_val   (b_rd_val),
    .i_w_en     (b_w_en),
    .i_busy_set (b_busy_set),
    .i_busy_rd  (b_busy_rd),
    .o_ready    (b_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Selectors: 0+k a val, 10+k a busy, 20 a ready, 30+k b val, 40+k b busy, 50 b ready
  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] exp;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end else begin
      n_pass++;
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  function automatic logic [63:0] obs_of(input int sel);
    logic [63:0] v;
    v = '0;
    if (sel < 10)       v = 64'(a_rs_val[sel*32 +: 32]);
    else if (sel < 20)  v = 64'(a_rs_busy[sel-10]);
    else if (sel == 20) v = 64'(a_ready);
    else if (sel < 40)  v = b_rs_val[(sel-30)*64 +: 64];
    else if (sel < 50)  v = 64'(b_rs_busy[sel-40]);
    else                v = 64'(b_ready);
    return v;
  endfunction

  task automatic push(input string tag, input int sel, input logic [63:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    q_exp.push_back(e);
  endtask

  task automatic settle();
    exp_t e;
    #1;
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      check_eq(e.tag, obs_of(e.sel), e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a_rs(input logic [4:0] p0, input logic [4:0] p1);
    a_rs = {p1, p0};
  endtask

  task automatic set_b_rs(input logic [3:0] p0, input logic [3:0] p1, input logic [3:0] p2);
    b_rs = {p2, p1, p0};
  endtask

  task automatic wait_ready(output int n1, output int n2);
    n1 = 0;
    n2 = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (a_ready && n1 == 0) n1 = i;
      if (b_ready && n2 == 0) n2 = i;
      if (n1 != 0 && n2 != 0) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n1;
    int n2;

    // Reset with writes and busy-sets held active through CLEAR
    a_rst = 1'b1; b_rst = 1'b1;
    a_w_en = 1'b1; a_rd = 5'd5; a_rd_val = 32'hDEADBEEF;
    a_busy_set = 1'b1; a_busy_rd = 5'd5; set_a_rs(5'd5, 5'd5);
    b_w_en = 1'b0; b_rd = '0; b_rd_val = '0; b_busy_set = 1'b0; b_busy_rd = '0;
    set_b_rs(4'd0, 4'd0, 4'd0);
    #12;
    push("a_rst_ready", 20, 64'd0);
    push("a_rst_val0",  0,  64'd0);
    push("a_rst_busy0", 10, 64'd0);
    push("b_rst_ready", 50, 64'd0);
    settle();
    a_rst = 1'b0; b_rst = 1'b0;
    wait_ready(n1, n2);
    check_eq("a_clear_edges", 64'(n1), 64'd32);
    check_eq("b_clear_edges", 64'(n2), 64'd16);

    // Writes and busy-sets during CLEAR must have been ignored
    a_w_en = 1'b0; a_busy_set = 1'b0;
    push("a_r5_val0",  0,  64'd0);
    push("a_r5_val1",  1,  64'd0);
    push("a_r5_busy0", 10, 64'd0);
    settle();

    step();
    a_w_en = 1'b1; a_rd = 5'd3; a_rd_val = 32'h12345678;
    step();
    a_w_en = 1'b0; set_a_rs(5'd3, 5'd3);
    push("a_r3_val0", 0, 64'h12345678);
    push("a_r3_val1", 1, 64'h12345678);
    settle();

    // Register 0 stays zero, even with a matching same-cycle write
    step();
    a_w_en = 1'b1; a_rd = 5'd0; a_rd_val = 32'hFFFFFFFF; set_a_rs(5'd0, 5'd3);
    push("a_x0_byp_val0", 0, 64'd0);
    push("a_x0_byp_val1", 1, 64'h12345678);
    settle();
    step();
    a_w_en = 1'b0;
    push("a_x0_val0", 0, 64'd0);
    settle();

    step();
    a_w_en = 1'b1; a_rd = 5'd7; a_rd_val = 32'hA5A5A5A5; set_a_rs(5'd7, 5'd3);
    push("a_byp_val0", 0, 64'hA5A5A5A5);
    push("a_byp_val1", 1, 64'h12345678);
    settle();
    step();
    a_w_en = 1'b0;
    push("a_r7_val0", 0, 64'hA5A5A5A5);
    settle();

    // Scoreboard on instance A
    step();
    a_busy_set = 1'b1; a_busy_rd = 5'd9;
    step();
    a_busy_set = 1'b0; set_a_rs(5'd9, 5'd3);
    push("a_sb_busy0", 10, 64'd1);
    push("a_sb_busy1", 11, 64'd0);
    settle();
    step();
    a_w_en = 1'b1; a_rd = 5'd9; a_rd_val = 32'h11; set_a_rs(5'd9, 5'd9);
    push("a_wb_byp_busy0", 10, 64'd0);
    push("a_wb_byp_val1",  1,  64'h11);
    settle();
    step();
    a_w_en = 1'b0;
    push("a_wb_busy0", 10, 64'd0);
    push("a_wb_val0",  0,  64'h11);
    settle();
    step();
    a_w_en = 1'b1; a_rd = 5'd9; a_rd_val = 32'h22;
    a_busy_set = 1'b1; a_busy_rd = 5'd9;
    push("a_setwr_busy0", 10, 64'd1);
    push("a_setwr_val0",  0,  64'h22);
    settle();
    step();
    a_w_en = 1'b0; a_busy_set = 1'b0;
    push("a_setwr_busy_after", 11, 64'd1);
    push("a_setwr_val_after",  1,  64'h22);
    settle();
    step();
    a_busy_set = 1'b1; a_busy_rd = 5'd0;
    step();
    a_busy_set = 1'b0; set_a_rs(5'd0, 5'd9);
    push("a_x0_busy0", 10, 64'd0);
    settle();

    // Instance B: no bypass, old value read in the write cycle
    step();
    b_w_en = 1'b1; b_rd = 4'd4; b_rd_val = 64'h1111_2222_3333_4444;
    step();
    b_rd_val = 64'h5555_6666_7777_8888; set_b_rs(4'd4, 4'd0, 4'd4);
    push("b_nobyp_val0", 30, 64'h1111_2222_3333_4444);
    push("b_nobyp_val1", 31, 64'd0);
    push("b_nobyp_val2", 32, 64'h1111_2222_3333_4444);
    settle();
    step();
    b_w_en = 1'b0;
    push("b_r4_val2", 32, 64'h5555_6666_7777_8888);
    settle();

    // Instance B: load writeback clears pending on the following cycle
    step();
    b_busy_set = 1'b1; b_busy_rd = 4'd9;
    step();
    b_busy_set = 1'b0; set_b_rs(4'd9, 4'd4, 4'd9);
    push("b_sb_busy0", 40, 64'd1);
    push("b_sb_busy1", 41, 64'd0);
    settle();
    step();
    b_w_en = 1'b1; b_rd = 4'd9; b_rd_val = 64'h11;
    push("b_wb_busy_now", 42, 64'd1);
    settle();
    step();
    b_w_en = 1'b0;
    push("b_wb_busy_next", 42, 64'd0);
    push("b_wb_val0",      30, 64'h11);
    settle();

    // Mid-clear reset on instance A
    a_rst = 1'b1;
    #1;
    a_rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    push("a_midclr_ready", 20, 64'd0);
    settle();
    a_rst = 1'b1;
    set_a_rs(5'd9, 5'd3);
    push("a_rst2_ready", 20, 64'd0);
    push("a_rst2_busy0", 10, 64'd0);
    settle();
    a_rst = 1'b0;
    wait_ready(n1, n2);
    check_eq("a_reclear_edges", 64'(n1), 64'd32);
    push("a_reclr_val0",  0,  64'd0);
    push("a_reclr_val1",  1,  64'd0);
    push("a_reclr_busy0", 10, 64'd0);
    settle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
